// File: rtl/uxn_ram_pkg.sv
// Shared types and constants for the UXN dual-port word RAM.
// The CLEAR state only exists when UXN_RAM_CLEAR_EN is defined.
package uxn_ram_pkg;

    localparam int UXN_ADDR_W_DEF = 16;
    localparam int BYTE_W         = 8;

    // Big-endian lanes of a 16-bit short: high byte lives at the lower address.
    localparam int BE_HI_LSB = 8;
    localparam int BE_LO_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SECOND = 2'd1
`ifdef UXN_RAM_CLEAR_EN
        , ST_CLEAR = 2'd2
`endif
    } ram_state_e;

`ifdef UXN_RAM_CLEAR_EN
    localparam ram_state_e ST_RESET = ST_CLEAR;
`else
    localparam ram_state_e ST_RESET = ST_IDLE;
`endif

    function automatic logic [15:0] be_pack(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/uxn_ram_core.sv
// Bare 2^ADDR_W x 8 storage: one write/read port (A) and one read port (B),
// both with registered, read-first outputs.
module uxn_ram_core
    import uxn_ram_pkg::*;
#(
    parameter int ADDR_W = UXN_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_a_we,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [7:0]        i_a_wdata,
    output logic [7:0]        o_a_rdata,
    input  logic [ADDR_W-1:0] i_b_addr,
    output logic [7:0]        o_b_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [BYTE_W-1:0] r_mem [0:DEPTH-1];
    logic [7:0]        r_a_rdata;
    logic [7:0]        r_b_rdata;

    // NOTE: the array itself is never reset so it maps onto block RAM; only
    // the read registers take the synchronous reset.
    always_ff @(posedge clk) begin
        if (i_a_we) begin
            r_mem[i_a_addr] <= i_a_wdata;
        end
    end

    // Both reads see the pre-write contents on a same-edge write (read-first).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_rdata <= 8'h00;
            r_b_rdata <= 8'h00;
        end else begin
            r_a_rdata <= r_mem[i_a_addr];
            r_b_rdata <= r_mem[i_b_addr];
        end
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/uxn_ram_dp_word.sv
// UXN RAM with a byte/short (big-endian) request port A and a read-only port B.
// Optional power-up clear sequence enabled by defining UXN_RAM_CLEAR_EN.
module uxn_ram_dp_word
    import uxn_ram_pkg::*;
#(
    parameter int ADDR_W      = UXN_ADDR_W_DEF,
    parameter int RDATA_B_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_short,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [15:0]       a_wdata,
    output logic              a_ready,
    output logic              a_valid,
    output logic [15:0]       a_rdata,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [7:0]        b_data
);

    ram_state_e        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic              r_short;
    logic [15:0]       r_wdata;
    logic [7:0]        r_hi;
    logic              r_a_valid;
    logic [15:0]       r_a_hold;
`ifdef UXN_RAM_CLEAR_EN
    logic [ADDR_W-1:0] r_clr_addr;
`endif

    logic              w_core_we;
    logic [ADDR_W-1:0] w_core_addr;
    logic [7:0]        w_core_wdata;
    logic [7:0]        w_core_a_rdata;
    logic [7:0]        w_core_b_rdata;
    logic [ADDR_W-1:0] w_addr_lo;
    logic [15:0]       w_a_result;

    assign a_ready   = (r_state == ST_IDLE);
    assign w_addr_lo = r_addr + 1'b1;

    // Core port A steering. Writes are suppressed while reset is asserted so a
    // pending second byte is dropped and a restarted clear begins cleanly.
    always_comb begin
        w_core_we    = 1'b0;
        w_core_addr  = a_addr;
        w_core_wdata = a_wdata[BE_LO_LSB +: BYTE_W];
        if (rst_n) begin
            case (r_state)
                ST_IDLE: begin
                    if (a_req) begin
                        w_core_we    = a_we;
                        w_core_wdata = a_short ? a_wdata[BE_HI_LSB +: BYTE_W]
                                               : a_wdata[BE_LO_LSB +: BYTE_W];
                    end
                end
                ST_SECOND: begin
                    w_core_we    = r_we;
                    w_core_addr  = w_addr_lo;
                    w_core_wdata = r_wdata[BE_LO_LSB +: BYTE_W];
                end
`ifdef UXN_RAM_CLEAR_EN
                ST_CLEAR: begin
                    w_core_we    = 1'b1;
                    w_core_addr  = r_clr_addr;
                    w_core_wdata = 8'h00;
                end
`endif
                default: ;
            endcase
        end
    end

    uxn_ram_core #(
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_a_we    (w_core_we),
        .i_a_addr  (w_core_addr),
        .i_a_wdata (w_core_wdata),
        .o_a_rdata (w_core_a_rdata),
        .i_b_addr  (b_addr),
        .o_b_rdata (w_core_b_rdata)
    );

    // In the completion cycle the core output holds the byte read at the last
    // access edge (the only byte for a byte read, the low byte for a short).
    always_comb begin
        case ({r_short, r_we})
            2'b00:   w_a_result = {8'h00, w_core_a_rdata};
            2'b01:   w_a_result = {8'h00, r_wdata[BE_LO_LSB +: BYTE_W]};
            2'b10:   w_a_result = be_pack(r_hi, w_core_a_rdata);
            default: w_a_result = r_wdata;
        endcase
    end

    assign a_valid = r_a_valid;
    assign a_rdata = r_a_valid ? w_a_result : r_a_hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_RESET;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_short   <= 1'b0;
            r_wdata   <= 16'h0000;
            r_hi      <= 8'h00;
            r_a_valid <= 1'b0;
            r_a_hold  <= 16'h0000;
`ifdef UXN_RAM_CLEAR_EN
            r_clr_addr <= '0;
`endif
        end else begin
            r_a_valid <= 1'b0;
            if (r_a_valid) begin
                r_a_hold <= w_a_result;
            end
            case (r_state)
                ST_IDLE: begin
                    if (a_req) begin
                        r_we    <= a_we;
                        r_short <= a_short;
                        r_wdata <= a_wdata;
                        r_addr  <= a_addr;
                        if (a_short) begin
                            r_state <= ST_SECOND;
                        end else begin
                            r_a_valid <= 1'b1;
                        end
                    end
                end
                ST_SECOND: begin
                    r_hi      <= w_core_a_rdata;
                    r_a_valid <= 1'b1;
                    r_state   <= ST_IDLE;
                end
`ifdef UXN_RAM_CLEAR_EN
                ST_CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == '1) begin
                        r_state <= ST_IDLE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    generate
        if (RDATA_B_REG != 0) begin : g_b_reg
            logic [7:0] r_b_data;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_b_data <= 8'h00;
                end else begin
                    r_b_data <= w_core_b_rdata;
                end
            end
            assign b_data = r_b_data;
        end else begin : g_b_direct
            assign b_data = w_core_b_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_uxn_ram_dp_word.sv
// Directed self-checking bench for uxn_ram_dp_word (port B latency 2).
// With UXN_RAM_CLEAR_EN defined the DUT is built with ADDR_W=8 and the clear sequence is checked.
module tb_uxn_ram_dp_word;

`ifdef UXN_RAM_CLEAR_EN
    localparam int AW      = 8;
    localparam int CLR_CYC = 256;
`else
    localparam int AW      = 16;
    localparam int CLR_CYC = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req;
    logic          a_we;
    logic          a_short;
    logic [AW-1:0] a_addr;
    logic [15:0]   a_wdata;
    logic          a_ready;
    logic          a_valid;
    logic [15:0]   a_rdata;
    logic [AW-1:0] b_addr;
    logic [7:0]    b_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uxn_ram_dp_word #(
        .ADDR_W      (AW),
        .RDATA_B_REG (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_req   (a_req),
        .a_we    (a_we),
        .a_short (a_short),
        .a_addr  (a_addr),
        .a_wdata (a_wdata),
        .a_ready (a_ready),
        .a_valid (a_valid),
        .a_rdata (a_rdata),
        .b_addr  (b_addr),
        .b_data  (b_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one port A request at a negedge and wait for completion. After the
    // accept edge the other port A inputs are scrambled; they must be ignored.
    task automatic a_op(input logic we, input logic sh, input logic [15:0] addr,
                        input logic [15:0] wdata, output logic [15:0] rd,
                        output int lat, output int busy);
        a_req   = 1'b1;
        a_we    = we;
        a_short = sh;
        a_addr  = addr[AW-1:0];
        a_wdata = wdata;
        lat  = 0;
        busy = 0;
        do begin
            @(negedge clk);
            lat++;
            a_req   = 1'b0;
            a_we    = ~we;
            a_short = ~sh;
            a_addr  = ~addr[AW-1:0];
            a_wdata = ~wdata;
            if (!a_ready) busy++;
        end while (!a_valid && lat < 8);
        rd = a_rdata;
    endtask

    task automatic b_read(input logic [15:0] addr, output logic [7:0] data);
        b_addr = addr[AW-1:0];
        repeat (2) @(negedge clk);
        data = b_data;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!a_ready && cnt < 70000) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    logic [15:0] rd;
    logic [7:0]  bd;
    int          lat;
    int          busy;
    int          cnt;
    logic [7:0]  exp_0400;
    logic [7:0]  exp_0401;

    initial begin
        rst_n   = 1'b0;
        a_req   = 1'b0;
        a_we    = 1'b0;
        a_short = 1'b0;
        a_addr  = '0;
        a_wdata = 16'h0000;
        b_addr  = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", a_valid, 0);
        check("rst_rdata", a_rdata, 0);
        check("rst_bdata", b_data, 0);
        rst_n = 1'b1;
        wait_ready(cnt);
        check("rst_busy_cycles", cnt, CLR_CYC);

        // Byte write then back-to-back byte read.
        a_op(1'b1, 1'b0, 16'h0100, 16'h33A5, rd, lat, busy);
        check("bw_lat", lat, 1);
        check("bw_rdata", rd, 16'h00A5);
        check("bw_busy", busy, 0);
        a_op(1'b0, 1'b0, 16'h0100, 16'h0000, rd, lat, busy);
        check("br_lat", lat, 1);
        check("br_rdata", rd, 16'h00A5);
        @(negedge clk);
        check("idle_valid", a_valid, 0);
        check("idle_hold", a_rdata, 16'h00A5);

        // Short round trip.
        a_op(1'b1, 1'b1, 16'h0200, 16'hBEEF, rd, lat, busy);
        check("sw_lat", lat, 2);
        check("sw_busy", busy, 1);
        check("sw_rdata", rd, 16'hBEEF);
        a_op(1'b0, 1'b0, 16'h0200, 16'h0000, rd, lat, busy);
        check("sw_hi_byte", rd, 16'h00BE);
        a_op(1'b0, 1'b0, 16'h0201, 16'h0000, rd, lat, busy);
        check("sw_lo_byte", rd, 16'h00EF);
        a_op(1'b0, 1'b1, 16'h0200, 16'h0000, rd, lat, busy);
        check("sr_lat", lat, 2);
        check("sr_rdata", rd, 16'hBEEF);
        b_read(16'h0201, bd);
        check("b_read_0201", bd, 8'hEF);

        // Short access wrapping the top of memory.
        a_op(1'b1, 1'b1, 16'hFFFF, 16'h1234, rd, lat, busy);
        check("wrap_w_rdata", rd, 16'h1234);
        a_op(1'b0, 1'b0, 16'hFFFF, 16'h0000, rd, lat, busy);
        check("wrap_hi", rd, 16'h0012);
        a_op(1'b0, 1'b0, 16'h0000, 16'h0000, rd, lat, busy);
        check("wrap_lo", rd, 16'h0034);
        a_op(1'b0, 1'b1, 16'hFFFF, 16'h0000, rd, lat, busy);
        check("wrap_r_rdata", rd, 16'h1234);

        // Read-during-write on port B: old data first, new data next.
        a_op(1'b1, 1'b0, 16'h0300, 16'h0011, rd, lat, busy);
        b_addr  = 16'h0300;
        a_req   = 1'b1;
        a_we    = 1'b1;
        a_short = 1'b0;
        a_addr  = 16'h0300;
        a_wdata = 16'h0022;
        @(negedge clk);
        a_req = 1'b0;
        @(negedge clk);
        check("rdw_old", b_data, 8'h11);
        @(negedge clk);
        check("rdw_new", b_data, 8'h22);

        // Reset during the second cycle of a short write.
        a_op(1'b1, 1'b0, 16'h0400, 16'h0000, rd, lat, busy);
        a_op(1'b1, 1'b0, 16'h0401, 16'h005C, rd, lat, busy);
        a_req   = 1'b1;
        a_we    = 1'b1;
        a_short = 1'b1;
        a_addr  = 16'h0400;
        a_wdata = 16'hAAAA;
        @(negedge clk);
        a_req = 1'b0;
        check("ms_in_second", a_ready, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("ms_rst_valid", a_valid, 0);
        check("ms_rst_rdata", a_rdata, 0);
        rst_n = 1'b1;
        wait_ready(cnt);
        check("ms_busy_cycles", cnt, CLR_CYC);
        @(negedge clk);
        check("ms_no_valid", a_valid, 0);
`ifdef UXN_RAM_CLEAR_EN
        exp_0400 = 8'h00;
        exp_0401 = 8'h00;
`else
        exp_0400 = 8'hAA;
        exp_0401 = 8'h5C;
`endif
        a_op(1'b0, 1'b0, 16'h0400, 16'h0000, rd, lat, busy);
        check("ms_hi_written", rd, {8'h00, exp_0400});
        a_op(1'b0, 1'b0, 16'h0401, 16'h0000, rd, lat, busy);
        check("ms_lo_unchanged", rd, {8'h00, exp_0401});

`ifdef UXN_RAM_CLEAR_EN
        // Clear sequence wipes every byte after a fresh reset.
        a_op(1'b1, 1'b0, 16'h0010, 16'h0077, rd, lat, busy);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ready(cnt);
        check("clr_cycles", cnt, 256);
        begin
            logic [15:0] acc;
            acc = 16'h0000;
            for (int i = 0; i < 256; i++) begin
                a_op(1'b0, 1'b0, 16'(i), 16'h0000, rd, lat, busy);
                acc = acc | rd;
            end
            check("clr_all_zero", acc, 16'h0000);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uxn_ram_dp_word.md
UXN_RAM_DP_WORD -- requirements
Module: uxn_ram_dp_word

Interface
REQ-001 Parameter ADDR_W, default 16: address width; the RAM holds 2^ADDR_W bytes.
REQ-002 Parameter RDATA_B_REG, default 1: 1 adds an output register on port B (latency 2); 0 gives latency 1.
REQ-003 Clock and reset: one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 a_req  in  1  port A request; accepted on a rising edge where a_req and a_ready are both 1.
REQ-007 a_we  in  1  1 = write, 0 = read.
REQ-008 a_short  in  1  1 = 16-bit big-endian access, 0 = byte access.
REQ-009 a_addr  in  ADDR_W  port A byte address.
REQ-010 a_wdata  in  16  write data; bits [7:0] are used for a byte access.
REQ-011 a_ready  out  1  port A can accept a request this cycle.
REQ-012 a_valid  out  1  one-cycle completion pulse.
REQ-013 a_rdata  out  16  result data; valid while a_valid is 1.
REQ-014 b_addr  in  ADDR_W  port B read address, sampled every cycle.
REQ-015 b_data  out  8  port B read data.

Function
REQ-016 States: CLEAR, IDLE and SECOND. a_ready is 1 only in IDLE.
REQ-017 Byte access accepted in IDLE:
- the RAM access happens at the accept edge;
- a_valid is 1 in the following cycle;
- the FSM stays in IDLE.
REQ-018 Byte read result: a_rdata = {8'h00, mem[a_addr]}.
REQ-019 Byte write: a_rdata = {8'h00, a_wdata[7:0]} (write-through).
REQ-020 Short access, first edge: the access is to a_addr (high byte), the address is latched, and the FSM moves to SECOND.
REQ-021 Short access, SECOND edge:
- the access is to (latched address + 1) mod 2^ADDR_W (low byte);
- this wraps 0xFFFF to 0x0000;
- the FSM then returns to IDLE.
REQ-022 Short access completion: a_valid is 1 in the cycle after the SECOND edge, i.e. 2 cycles after accept.
- Read: a_rdata = {high byte, low byte}.
- Write: a_rdata = a_wdata, latched at accept.
REQ-023 Port A inputs other than a_req are ignored while the FSM is in SECOND.
REQ-024 In IDLE, a new request may be accepted on the same edge where a_valid rises (back-to-back operation).
REQ-025 Port B is read-only.
- Latency is 1 cycle (RDATA_B_REG=0) or 2 cycles (RDATA_B_REG=1).
- On a same-address, same-edge port A write, port B returns the old data (read-first).
REQ-026 Outside active results, a_valid is 0 and a_rdata holds its last value.

Reset
REQ-027 When rst_n=0 at a rising edge:
- a_valid, a_rdata and b_data go to 0;
- any pending second byte is abandoned;
- the FSM enters CLEAR, or IDLE if UXN_RAM_CLEAR_EN is undefined.
REQ-028 Reset does not change RAM contents except through the CLEAR sequence.

Configuration
REQ-029 The macro is UXN_RAM_CLEAR_EN.
REQ-030 With UXN_RAM_CLEAR_EN defined:
- CLEAR writes 8'h00 to addresses 0 through 2^ADDR_W-1, one per cycle;
- the FSM then enters IDLE, taking 2^ADDR_W cycles with a_ready=0;
- reset asserted during CLEAR restarts the sequence at address 0;
- port B reads stay live during CLEAR.
REQ-031 Without UXN_RAM_CLEAR_EN:
- no CLEAR state exists;
- a_ready=1 in the first cycle after reset is released;
- initial RAM contents are undefined in the simulator.

Structure
REQ-032 Package uxn_ram_pkg holds the FSM state enum, the ADDR_W default, and the big-endian byte-lane constants.
REQ-033 Sub-module uxn_ram_core holds the bare storage:
- 2^ADDR_W x 8 array;
- one write/read port and one read port;
- read-first behaviour.
The FSM, address increment and data assembly stay in uxn_ram_dp_word.

Verification
REQ-034 Write/read bytes: write byte 8'hA5 to 16'h0100, then read byte 16'h0100 -> a_valid 1 cycle after accept, a_rdata=16'h00A5.
REQ-035 Short round trip: short write 16'hBEEF at 16'h0200 -> mem[0200]=BE, mem[0201]=EF, a_ready low for 1 cycle; then short read 16'h0200 -> a_rdata=16'hBEEF 2 cycles after accept.
REQ-036 Wrap-around: short write 16'h1234 at 16'hFFFF -> mem[FFFF]=12, mem[0000]=34; then short read 16'hFFFF -> 16'h1234.
REQ-037 Read-during-write: mem[0300]=11; port A writes 22 to 0300 while b_addr=0300 on the same edge -> b_data=11 after B latency, then 22 on the next read.
REQ-038 Reset mid-short: rst_n low in SECOND of a short write of 16'hAAAA to 16'h0400 -> no a_valid, mem[0401] unchanged.
REQ-039 Clear sequence (UXN_RAM_CLEAR_EN, ADDR_W=8): preload nonzero data, then reset -> a_ready low for exactly 256 cycles, after which every byte reads 0.
